// File: rtl/clmul_seq.sv
// Sequential carry-less multiplier producing the unreduced 2*DATA_WIDTH product.
// Define CLMUL_RADIX4_EN to consume two multiplier bits per cycle.
module clmul_seq #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op_enable,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH-1:0]         a_in,
  input  logic [DATA_WIDTH-1:0]         b_in,
  output logic [2*DATA_WIDTH-1:0]       out,
  output logic                          op_finish
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned GW = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned CW = GW + 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [GW-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   out_q, out_d;
  logic            fin_q, fin_d;

  logic [GW-1:0]   m_sel;
  logic [DW-1:0]   op_mask;
  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   step;
  logic            last;

  assign out       = out_q;
  assign op_finish = fin_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      fin_q   <= fin_d;
    end
  end

  // Out-of-range degrees fall back to the full operand width
  always_comb begin
    m_sel   = (polyn_grade < GW'(2) || polyn_grade > GW'(DW)) ? GW'(DW) : polyn_grade;
    op_mask = ~({DW{1'b1}} << m_sel);
    a_ext   = PW'(a_q);
  end

`ifdef CLMUL_RADIX4_EN
  logic [1:0] b_pair;
  always_comb begin
    b_pair = 2'(b_q >> cnt_q);
    step   = (b_pair[0] ? (a_ext << cnt_q) : '0)
           ^ (b_pair[1] ? (a_ext << (cnt_q + CW'(1))) : '0);
    last   = (cnt_q + CW'(2)) >= CW'(m_q);
  end
  localparam logic [CW-1:0] CNT_INC = CW'(2);
`else
  logic b_bit;
  always_comb begin
    b_bit = 1'(b_q >> cnt_q);
    step  = b_bit ? (a_ext << cnt_q) : '0;
    last  = cnt_q == (CW'(m_q) - CW'(1));
  end
  localparam logic [CW-1:0] CNT_INC = CW'(1);
`endif

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    fin_d   = fin_q;

    case (state_q)
      IDLE: begin
        if (op_enable) begin
          a_d     = a_in & op_mask;
          b_d     = b_in & op_mask;
          m_d     = m_sel;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_q ^ step;
        cnt_d = cnt_q + CNT_INC;
        if (last) begin
          out_d   = acc_q ^ step;
          fin_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase

    // Dropping the enable aborts from any state; no partial result survives
    if (!op_enable) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      m_d     = '0;
      cnt_d   = '0;
      acc_d   = '0;
      out_d   = '0;
      fin_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_clmul_seq.sv
// Randomized self-checking bench for clmul_seq against a bitwise polynomial product model.
module tb_clmul_seq;

  localparam int unsigned DW = 4;

  logic           clk;
  logic           rst;
  logic           op_enable;
  logic [2:0]     polyn_grade;
  logic [DW-1:0]  a_in;
  logic [DW-1:0]  b_in;
  logic [2*DW-1:0] out;
  logic           op_finish;

  int checks;
  int errors;

  clmul_seq #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_enable  (op_enable),
    .polyn_grade(polyn_grade),
    .a_in       (a_in),
    .b_in       (b_in),
    .out        (out),
    .op_finish  (op_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_of(input logic [2:0] pg);
    if (pg < 3'd2 || pg > 3'(DW)) return DW;
    return int'(pg);
  endfunction

  function automatic int lat(input int m);
`ifdef CLMUL_RADIX4_EN
    return (m + 1) / 2;
`else
    return m;
`endif
  endfunction

  // Polynomial product: coefficient i+j flips for every a_j*b_i term below degree m
  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input int m);
    logic [2*DW-1:0] r;
    r = '0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < m; j++)
        if (a[j] && b[i]) r = r ^ ((2*DW)'(1) << (i + j));
    return r;
  endfunction

  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [2:0] pg,
                        output logic [2*DW-1:0] res, output int cyc);
    op_enable   = 1'b1;
    a_in        = a;
    b_in        = b;
    polyn_grade = pg;
    @(posedge clk); #1;
    cyc = 0;
    while (op_finish !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    res = out;
  endtask

  task automatic end_op();
    op_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_enable = 1'b0; polyn_grade = 3'd4; a_in = '0; b_in = '0;
    #2;
    checks++;
    if (out !== '0 || op_finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold out=%h fin=%b exp out=00 fin=0", out, op_finish);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out !== '0 || op_finish !== 1'b0) begin
      errors++;
      $display("FAIL reset_release out=%h fin=%b exp out=00 fin=0", out, op_finish);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0]   va [6] = '{4'hB, 4'hF, 4'hF, 4'h0, 4'hF, 4'h3};
    logic [DW-1:0]   vb [6] = '{4'h6, 4'hF, 4'hF, 4'hF, 4'hF, 4'h3};
    logic [2:0]      vp [6] = '{3'd4, 3'd4, 3'd3, 3'd4, 3'd0, 3'd4};
    logic [2*DW-1:0] ve [6] = '{8'h3A, 8'h55, 8'h15, 8'h00, 8'h55, 8'h05};
    logic [2*DW-1:0] res;
    int cyc;
    for (int v = 0; v < 6; v++) begin
      run_op(va[v], vb[v], vp[v], res, cyc);
      checks++;
      if (res !== ve[v]) begin
        errors++;
        $display("FAIL directed_%0d_value got %h exp %h", v, res, ve[v]);
      end
      checks++;
      if (cyc !== lat(m_of(vp[v]))) begin
        errors++;
        $display("FAIL directed_%0d_latency got %0d exp %0d", v, cyc, lat(m_of(vp[v])));
      end
      for (int h = 0; h < 3; h++) begin
        @(posedge clk); #1;
        checks++;
        if (out !== ve[v] || op_finish !== 1'b1) begin
          errors++;
          $display("FAIL directed_%0d_hold out=%h fin=%b exp %h fin=1", v, out, op_finish, ve[v]);
        end
      end
      end_op();
      checks++;
      if (out !== '0 || op_finish !== 1'b0) begin
        errors++;
        $display("FAIL directed_%0d_clear out=%h fin=%b exp 00 fin=0", v, out, op_finish);
      end
    end
  endtask

  task automatic test_abort();
    logic [2*DW-1:0] res;
    int cyc;
    op_enable = 1'b1; a_in = 4'hF; b_in = 4'hF; polyn_grade = 3'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (op_finish !== 1'b0) begin
      errors++;
      $display("FAIL abort_early_finish fin=%b exp 0", op_finish);
    end
    op_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out !== '0 || op_finish !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear out=%h fin=%b exp 00 fin=0", out, op_finish);
    end
    run_op(4'h3, 4'h3, 3'd4, res, cyc);
    checks++;
    if (res !== 8'h05 || cyc !== lat(4)) begin
      errors++;
      $display("FAIL abort_restart got %h cyc %0d exp 05 cyc %0d", res, cyc, lat(4));
    end
    end_op();
  endtask

  task automatic test_async_reset();
    logic [2*DW-1:0] res;
    int cyc;
    op_enable = 1'b1; a_in = 4'hB; b_in = 4'h6; polyn_grade = 3'd4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out !== '0 || op_finish !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_mul out=%h fin=%b exp 00 fin=0", out, op_finish);
    end
    op_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(4'hF, 4'hF, 3'd4, res, cyc);
    checks++;
    if (res !== 8'h55) begin
      errors++;
      $display("FAIL async_rst_pre_done got %h exp 55", res);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out !== '0 || op_finish !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_done out=%h fin=%b exp 00 fin=0", out, op_finish);
    end
    op_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(4'hB, 4'h6, 3'd4, res, cyc);
    checks++;
    if (res !== 8'h3A || cyc !== lat(4)) begin
      errors++;
      $display("FAIL async_rst_fresh got %h cyc %0d exp 3a cyc %0d", res, cyc, lat(4));
    end
    end_op();
  endtask

  task automatic test_operand_change();
    logic [DW-1:0]   a, b;
    logic [2:0]      pg;
    logic [2*DW-1:0] exp_v, res;
    int cyc;
    for (int t = 0; t < 4; t++) begin
      a = DW'($urandom); b = DW'($urandom); pg = 3'($urandom_range(2, 4));
      exp_v = ref_mul(a, b, m_of(pg));
      op_enable = 1'b1; a_in = a; b_in = b; polyn_grade = pg;
      @(posedge clk); #1;
      cyc = 0;
      while (op_finish !== 1'b1 && cyc < 40) begin
        a_in = DW'($urandom); b_in = DW'($urandom); polyn_grade = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        cyc++;
      end
      res = out;
      checks++;
      if (res !== exp_v || cyc !== lat(m_of(pg))) begin
        errors++;
        $display("FAIL opchg_%0d got %h cyc %0d exp %h cyc %0d", t, res, cyc, exp_v, lat(m_of(pg)));
      end
      for (int h = 0; h < 3; h++) begin
        a_in = DW'($urandom); b_in = DW'($urandom); polyn_grade = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        checks++;
        if (out !== exp_v || op_finish !== 1'b1) begin
          errors++;
          $display("FAIL opchg_%0d_hold out=%h fin=%b exp %h fin=1", t, out, op_finish, exp_v);
        end
      end
      end_op();
    end
  endtask

  task automatic test_random();
    logic [DW-1:0]   a, b;
    logic [2:0]      pg;
    logic [2*DW-1:0] exp_v, res;
    int cyc;
    for (int t = 0; t < 30; t++) begin
      a = DW'($urandom); b = DW'($urandom); pg = 3'($urandom_range(0, 7));
      exp_v = ref_mul(a, b, m_of(pg));
      run_op(a, b, pg, res, cyc);
      checks++;
      if (res !== exp_v) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h pg=%0d got %h exp %h", t, a, b, pg, res, exp_v);
      end
      checks++;
      if (cyc !== lat(m_of(pg))) begin
        errors++;
        $display("FAIL random_%0d_latency got %0d exp %0d", t, cyc, lat(m_of(pg)));
      end
      end_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0]   a, b;
    logic [2:0]      pg;
    logic [2*DW-1:0] exp_v, res;
    int cyc;
    for (int t = 0; t < 6; t++) begin
      a = DW'($urandom); b = DW'($urandom); pg = 3'($urandom_range(2, 4));
      exp_v = ref_mul(a, b, m_of(pg));
      run_op(a, b, pg, res, cyc);
      checks++;
      if (res !== exp_v || cyc !== lat(m_of(pg))) begin
        errors++;
        $display("FAIL b2b_%0d got %h cyc %0d exp %h cyc %0d", t, res, cyc, exp_v, lat(m_of(pg)));
      end
      end_op();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_abort();
    test_async_reset();
    test_operand_change();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clmul_seq.md
# clmul_seq

Sequential carry-less (GF(2)[x]) polynomial multiplier that forms the unreduced double-width product consumed by the GF(2^m) reduction stage. It sits directly upstream of the reducer in the sequential datapath. Its `out`/`op_finish` pair drives the reducer's `reduc_in`/`op_enable`. It processes one multiplier bit per cycle (two with the radix-4 option), so area stays small for wide fields.

## Interface
- `DATA_WIDTH`, default 4: maximum field degree m; operand width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high; clears all state immediately.
- `op_enable` input 1: level-sensitive operation enable. A low-to-high transition starts an operation. Low aborts and clears.
- `polyn_grade` input $clog2(DATA_WIDTH)+1: effective field degree m, valid range 2..DATA_WIDTH. Sampled only at start.
- `a_in` input DATA_WIDTH: multiplicand; bits at m and above are ignored.
- `b_in` input DATA_WIDTH: multiplier; bits at m and above are ignored.
- `out` output 2*DATA_WIDTH: carry-less product a·b; bits 2m-1 and above are always 0.
- `op_finish` output 1: product valid. Held high until `op_enable` drops.

## Operation
- **FSM states:** IDLE, MUL, DONE.
- **IDLE:**
  - `op_enable` sampled high: register `a_in` and `b_in`, masked to the low m bits.
  - Latch m. If `polyn_grade` is <2 or >DATA_WIDTH, use m = DATA_WIDTH.
  - Clear the 2*DATA_WIDTH accumulator and set the bit counter to 0; go to MUL.
- **MUL:**
  - Each cycle: acc ^= b[count] ? (a << count) : 0, then count++.
  - After the step with count = m-1: load `out` with the final acc, set `op_finish`, go to DONE.
- **DONE:** hold `out` and `op_finish` while `op_enable` stays high. Operand input changes are ignored.
- **`op_enable` low in any state:** at the next edge, go to IDLE and clear `out`, `op_finish`, acc and count. A new operation requires `op_enable` to be seen low for at least one edge.
- **Arithmetic:** XOR only, no carries. Shifts are zero-filled.
- **`rst` asserted:** state = IDLE; `out` = 0, `op_finish` = 0, all internal registers 0, independent of `clk`. Deassertion is synchronous to the design by construction; the integrator must release `rst` with `op_enable` low.

## Timing
- **Start:** edge E0 is the first edge with `op_enable` high in IDLE. Operands are captured at E0.
- **Accumulation:** edges E1..Em perform the m accumulation steps.
- **Result:** `out` and `op_finish` are valid after edge Em, i.e. m cycles after E0. With DATA_WIDTH=4 and m=4, `op_finish` rises 4 cycles after start.
- **Hold:** `out` is stable for every cycle in which `op_finish` = 1.
- **Abort:** `op_enable` low at edge Ek (0 ≤ k ≤ m) means `op_finish` = 0 and `out` = 0 after Ek. No partial result is ever flagged valid.
- **Simultaneous events:** `rst` overrides `op_enable`. `polyn_grade` changes after E0 have no effect.
- **Back-to-back:** minimum spacing is m+2 cycles (m compute cycles, DONE for one or more cycles, IDLE for one cycle).

## Configuration
- **`CLMUL_RADIX4_EN` defined:** each MUL step consumes two multiplier bits.
  - Step: acc ^= (b[c]·a << c) ^ (b[c+1]·a << (c+1)), then count += 2.
  - For odd m, b[m] is treated as 0 (it is masked anyway).
  - `op_finish` is valid ceil(m/2) cycles after E0.
- **Undefined:** radix-2 behaviour as above. Results are bit-identical in both builds; only latency differs.

## Test plan
- DATA_WIDTH=4, m=4, a=0xB, b=0x6 -> `out`=0x3A, `op_finish` high 4 cycles after start (2 with `CLMUL_RADIX4_EN`), held while `op_enable` is high.
- m=4, a=0xF, b=0xF -> `out`=0x55; m=3 with the same inputs (masked to 0x7) -> `out`=0x15, latency 3 (2 with radix-4).
- a=0x0, b=0xF, m=4 -> `out`=0x00, `op_finish` still rises at the normal latency; `polyn_grade`=0 -> treated as m=4.
- Drop `op_enable` 2 cycles into MUL -> the next edge gives `out`=0 and `op_finish`=0. Re-raise with a=0x3, b=0x3 -> `out`=0x05.
- Assert `rst` asynchronously mid-MUL and in DONE -> `out`=0 and `op_finish`=0 immediately, without waiting for a clock edge. After release, a fresh operation (a=0xB, b=0x6) gives 0x3A.
- Change `a_in`, `b_in` and `polyn_grade` every cycle during MUL and DONE -> the result is unchanged from the values captured at E0.
